// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: owns the architectural PC, fetches one word at a time
// over a valid/ready memory port, hands it to decode and waits for retirement.
module pc_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic [63:0] NextPC,
  input  logic        Retire,
  output logic        IMemReqValid,
  input  logic        IMemReqReady,
  output logic [63:0] IMemAddr,
  input  logic        IMemRspValid,
  input  logic [31:0] IMemRspData,
  output logic        InstValid,
  input  logic        InstReady,
  output logic [31:0] Instruction,
  output logic [63:0] CurrentPC,
  output logic [31:0] RetireCount,
  output logic        Misaligned
);

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    WAIT  = 3'd1,
    ISSUE = 3'd2,
    EXEC  = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t      state, next_state;
  logic [63:0] pc;
  logic [31:0] inst_buf;
  logic [31:0] retire_cnt;
  logic        fault;
  logic        req_vld;
  logic        capture;
  logic        retire_ok;
  logic        retire_bad;

  always_comb begin
    next_state = state;
    capture    = 1'b0;
    retire_ok  = 1'b0;
    retire_bad = 1'b0;
    unique case (state)
      FETCH: begin
        // req_vld rather than the state alone: the cycle right after reset has no request out
        if (req_vld && IMemReqReady) next_state = WAIT;
      end
      WAIT: begin
        if (IMemRspValid) begin
          capture    = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        if (InstReady) next_state = EXEC;
      end
      EXEC: begin
        if (Retire) begin
          if (NextPC[1:0] == 2'b00) begin
            retire_ok  = 1'b1;
            next_state = FETCH;
          end else begin
            retire_bad = 1'b1;
            next_state = FAULT;
          end
        end
      end
      FAULT: next_state = FAULT;
      default: next_state = FETCH;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      inst_buf   <= 32'h0;
      retire_cnt <= 32'h0;
      fault      <= 1'b0;
      req_vld    <= 1'b0;
    end else begin
      state   <= next_state;
      // Registered request valid keeps the memory port free of input-to-output paths
      req_vld <= (next_state == FETCH);
      if (capture) inst_buf <= IMemRspData;
      if (retire_ok) pc <= NextPC;
      if (retire_ok || retire_bad) retire_cnt <= retire_cnt + 32'd1;
      if (retire_bad) fault <= 1'b1;
    end
  end

  assign IMemReqValid = req_vld;
  assign IMemAddr     = pc;
  assign InstValid    = (state == ISSUE);
  assign Instruction  = inst_buf;
  assign CurrentPC    = pc;
  assign RetireCount  = retire_cnt;
  assign Misaligned   = fault;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed instruction sequences plus a transaction-level
// model compared against the outputs on every falling edge.
module tb_pc_fetch_unit;
  localparam logic [63:0] RST_PC = 64'h100;

  logic        CLK = 1'b0;
  logic        Reset_L = 1'b0;
  logic [63:0] NextPC = 64'h0;
  logic        Retire = 1'b0;
  logic        IMemReqValid;
  logic        IMemReqReady = 1'b0;
  logic [63:0] IMemAddr;
  logic        IMemRspValid = 1'b0;
  logic [31:0] IMemRspData = 32'h0;
  logic        InstValid;
  logic        InstReady = 1'b0;
  logic [31:0] Instruction;
  logic [63:0] CurrentPC;
  logic [31:0] RetireCount;
  logic        Misaligned;

  pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .CLK(CLK), .Reset_L(Reset_L), .NextPC(NextPC), .Retire(Retire),
    .IMemReqValid(IMemReqValid), .IMemReqReady(IMemReqReady), .IMemAddr(IMemAddr),
    .IMemRspValid(IMemRspValid), .IMemRspData(IMemRspData),
    .InstValid(InstValid), .InstReady(InstReady), .Instruction(Instruction),
    .CurrentPC(CurrentPC), .RetireCount(RetireCount), .Misaligned(Misaligned)
  );

  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_tot  = 0;
  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Transaction-level model: what the fetch unit owes its neighbours
  logic [63:0] m_pc = RST_PC;
  logic [31:0] m_cnt = 0;
  logic [31:0] m_inst = 0;
  logic        m_mis = 0, m_out = 0, m_have = 0, m_dec = 0, m_started = 0;
  int          n_dec = 0;
  logic        req_exp;

  always @(negedge CLK) begin
    if (!Reset_L) begin
      m_pc = RST_PC; m_cnt = 0; m_inst = 0; m_mis = 0;
      m_out = 0; m_have = 0; m_dec = 0; m_started = 0;
    end
    req_exp = m_started && !m_mis && !m_out && !m_have && !m_dec;
    chk("m_req_valid", IMemReqValid, req_exp);
    chk("m_inst_valid", InstValid, m_have);
    chk("m_current_pc", CurrentPC, m_pc);
    if (IMemReqValid) chk("m_imem_addr", IMemAddr, m_pc);
    chk("m_instruction", Instruction, m_inst);
    chk("m_retire_count", RetireCount, m_cnt);
    chk("m_misaligned", Misaligned, m_mis);
    if (Reset_L) begin
      if (!m_started) m_started = 1'b1;
      else begin
        if (m_dec && Retire) begin
          m_cnt = m_cnt + 1;
          m_dec = 1'b0;
          if (NextPC[1:0] == 2'b00) m_pc = NextPC;
          else m_mis = 1'b1;
        end
        if (m_have && InstReady) begin
          m_have = 1'b0; m_dec = 1'b1; n_dec++;
        end
        if (m_out && IMemRspValid) begin
          m_out = 1'b0; m_have = 1'b1; m_inst = IMemRspData;
        end
        if (req_exp && IMemReqReady) m_out = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_req(output logic ok);
    for (int i = 0; i < 50 && !IMemReqValid; i++) step();
    ok = IMemReqValid;
    if (!ok) chk("wait_req_timeout", {63'h0, IMemReqValid}, 64'h1);
  endtask

  // One full instruction with programmable stalls; optional spurious Retire during ISSUE
  // and a response coincident with acceptance, both of which must be ignored.
  task automatic run_inst(input logic [31:0] data, input int rdly, input int rspdly,
                          input int decdly, input logic spurious, input logic early_rsp,
                          input logic [63:0] nxt, output logic [63:0] addr,
                          output int unsigned acc_cyc);
    logic ok;
    wait_req(ok);
    addr = IMemAddr;
    for (int i = 0; i < rdly; i++) step();
    IMemReqReady = 1'b1;
    if (early_rsp) begin IMemRspValid = 1'b1; IMemRspData = 32'hBAD0_BAD0; end
    acc_cyc = cyc;
    step();
    IMemReqReady = 1'b0; IMemRspValid = 1'b0;
    for (int i = 0; i < rspdly; i++) step();
    IMemRspValid = 1'b1; IMemRspData = data;
    step();
    IMemRspValid = 1'b0; IMemRspData = 32'h0;
    chk("issue_valid", {63'h0, InstValid}, 64'h1);
    chk("issue_instr", {32'h0, Instruction}, {32'h0, data});
    for (int i = 0; i < decdly; i++) begin
      if (spurious && i == 0) begin Retire = 1'b1; NextPC = 64'h200; end
      step();
      Retire = 1'b0;
    end
    InstReady = 1'b1;
    step();
    InstReady = 1'b0;
    Retire = 1'b1; NextPC = nxt;
    step();
    Retire = 1'b0;
  endtask

  logic [63:0] a;
  int unsigned c0, c1;
  logic ok;
  int reqs;

  initial begin
    // Reset held for 3 cycles
    Reset_L = 1'b0;
    repeat (3) step();
    chk("rst_req_valid", {63'h0, IMemReqValid}, 64'h0);
    chk("rst_inst_valid", {63'h0, InstValid}, 64'h0);
    chk("rst_current_pc", CurrentPC, 64'h100);
    chk("rst_imem_addr", IMemAddr, 64'h100);
    chk("rst_instruction", {32'h0, Instruction}, 64'h0);
    chk("rst_count", {32'h0, RetireCount}, 64'h0);
    chk("rst_misaligned", {63'h0, Misaligned}, 64'h0);
    Reset_L = 1'b1;
    step();
    chk("start_req_valid", {63'h0, IMemReqValid}, 64'h1);
    chk("start_addr", IMemAddr, 64'h100);
    chk("start_inst_valid", {63'h0, InstValid}, 64'h0);

    // Counter wrap, branching to 0
    dut.retire_cnt = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    run_inst(32'h1111_0000, 0, 0, 0, 1'b0, 1'b0, 64'h0, a, c0);
    chk("wrap_addr", a, 64'h100);
    chk("wrap_count", {32'h0, RetireCount}, 64'h0);

    // Zero-wait sequential loop: 0,4,8,12 at 4-cycle spacing
    for (int i = 0; i < 4; i++) begin
      run_inst(32'hA000_0000 + i, 0, 0, 0, 1'b0, 1'b0, 64'(i * 4 + 4), a, c1);
      chk("seq_addr", a, 64'(i * 4));
      if (i > 0) chk("seq_spacing", 64'(c1 - c0), 64'd4);
      c0 = c1;
    end
    chk("seq_count", {32'h0, RetireCount}, 64'h4);

    // Backpressure everywhere, spurious Retire in ISSUE, early response, then a far branch
    run_inst(32'hCAFE_F00D, 5, 3, 2, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, a, c0);
    chk("bp_addr", a, 64'h10);
    wait_req(ok);
    chk("branch_addr", IMemAddr, 64'hFFFF_FFFF_FFFF_FFF0);
    chk("branch_count", {32'h0, RetireCount}, 64'h5);

    // Misaligned target goes to the terminal fault
    run_inst(32'hDEAD_BEEF, 0, 0, 0, 1'b0, 1'b0, 64'h102, a, c0);
    chk("mis_flag", {63'h0, Misaligned}, 64'h1);
    chk("mis_pc", CurrentPC, 64'hFFFF_FFFF_FFFF_FFF0);
    chk("mis_count", {32'h0, RetireCount}, 64'h6);
    reqs = 0;
    IMemReqReady = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (IMemReqValid || InstValid) reqs++;
      step();
    end
    IMemReqReady = 1'b0;
    chk("fault_quiet", 64'(reqs), 64'h0);

    Reset_L = 1'b0;
    step();
    chk("fault_reset_mis", {63'h0, Misaligned}, 64'h0);
    Reset_L = 1'b1;

    // Reset while waiting on a response, then a stale response after release
    wait_req(ok);
    IMemReqReady = 1'b1;
    step();
    IMemReqReady = 1'b0;
    step();
    Reset_L = 1'b0;
    step();
    step();
    Reset_L = 1'b1;
    IMemRspValid = 1'b1; IMemRspData = 32'h5157_A1E0;
    step();
    IMemRspValid = 1'b0;
    step();
    chk("stale_instr", {32'h0, Instruction}, 64'h0);
    chk("stale_req_valid", {63'h0, IMemReqValid}, 64'h1);
    chk("stale_addr", IMemAddr, 64'h100);
    chk("stale_inst_valid", {63'h0, InstValid}, 64'h0);
    step();
    chk("decode_handshakes", 64'(n_dec), 64'd7);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
